// File: rtl/conv1d_requant_if.sv
// Handshake and config bus between the conv1d accumulator stream, the
// requantization stage and the CFU response path.
interface conv1d_requant_if #(
    parameter int INT32_SIZE = 32,
    parameter int BYTE_SIZE  = 8
);
    logic                  cfg_we;
    logic [2:0]            cfg_sel;
    logic [INT32_SIZE-1:0] cfg_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [INT32_SIZE-1:0] in_acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [BYTE_SIZE-1:0]  out_data;
    logic                  busy;
    logic                  cfg_err;

    modport master (
        output cfg_we, cfg_sel, cfg_data, in_valid, in_acc, out_ready,
        input  in_ready, out_valid, out_data, busy, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_data, in_valid, in_acc, out_ready,
        output in_ready, out_valid, out_data, busy, cfg_err
    );
endinterface

// File: rtl/conv1d_requant.sv
// Int32 accumulator -> int8 requantization: bias, TFLite-style fixed-point
// multiply/shift, output offset and activation clamp, as a stallable pipe.
module conv1d_requant #(
    parameter int INT32_SIZE = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    conv1d_requant_if.slave   bus
);
    localparam int W      = INT32_SIZE;
    localparam int B      = BYTE_SIZE;
    localparam int SW     = $clog2(W) + 1;
    localparam int STAGES = 4;

    typedef logic signed [W-1:0]   word_t;
    typedef logic signed [2*W-1:0] dword_t;
    typedef logic signed [W:0]     wide_t;

    localparam word_t  WMIN      = {1'b1, {(W-1){1'b0}}};
    localparam word_t  WMAX      = {1'b0, {(W-1){1'b1}}};
    localparam word_t  SHMAX     = word_t'(W - 1);
    localparam word_t  SHMIN     = word_t'(1 - W);
    localparam dword_t ONE2      = dword_t'(1);
    localparam dword_t NUDGE_POS = {{(W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
    localparam dword_t NUDGE_NEG = ONE2 - NUDGE_POS;
    localparam wide_t  QMAX      = wide_t'((2**(B-1)) - 1);
    localparam wide_t  QMIN      = wide_t'(-(2**(B-1)));

    // Configuration registers
    word_t                bias_q, mult_q, offset_q, amin_q, amax_q;
    logic signed [SW-1:0] shift_q;
    logic                 cfg_err_q;

    // Pipeline: [0] input capture, [1..4] S1..S4 results
    logic [STAGES:0]      vld_pipe_q;
    word_t                acc_q;
    word_t                x_q, x_d;
    logic [SW-2:0]        left_q, left_d, rsh1_q, rsh1_d, rsh2_q;
    word_t                z_q, z_d;
    word_t                r_q, r_d;
    logic [B-1:0]         out_q, out_d;

    logic  adv, in_fire, busy, cfg_ok;
    word_t cfg_val;

    assign adv     = !vld_pipe_q[STAGES] || bus.out_ready;
    assign in_fire = bus.in_valid && adv;
    assign busy    = |vld_pipe_q;
    assign cfg_ok  = bus.cfg_we && !busy && !in_fire;
    assign cfg_val = $signed(bus.cfg_data);

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.out_data  = out_q;
    assign bus.busy      = busy;
    assign bus.cfg_err   = cfg_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q    <= '0;
            mult_q    <= word_t'(32'h4000_0000);
            shift_q   <= '0;
            offset_q  <= '0;
            amin_q    <= word_t'(QMIN);
            amax_q    <= word_t'(QMAX);
            cfg_err_q <= 1'b0;
        end else if (cfg_ok) begin
            case (bus.cfg_sel)
                3'd0: bias_q   <= cfg_val;
                3'd1: mult_q   <= cfg_val;
                3'd2: begin
                    if (cfg_val > SHMAX)      shift_q <= SW'(W - 1);
                    else if (cfg_val < SHMIN) shift_q <= SW'(1 - W);
                    else                      shift_q <= cfg_val[SW-1:0];
                end
                3'd3: offset_q <= cfg_val;
                3'd4: amin_q   <= cfg_val;
                3'd5: amax_q   <= cfg_val;
                default: ;
            endcase
        end else if (bus.cfg_we) begin
            cfg_err_q <= 1'b1;
        end
    end

    // S1: bias add and split of the signed shift into left/right amounts
    logic signed [SW-1:0] neg_shift;
    always_comb begin
        neg_shift = -shift_q;
        x_d       = acc_q + bias_q;
        left_d    = shift_q[SW-1] ? '0 : shift_q[SW-2:0];
        rsh1_d    = shift_q[SW-1] ? neg_shift[SW-2:0] : '0;
    end

    // S2: wrapping left shift then saturating rounding doubling high multiply
    word_t  y;
    dword_t prod, sum, quot;
    always_comb begin
        y    = x_q << left_q;
        prod = dword_t'(y) * dword_t'(mult_q);
        sum  = prod + (prod[2*W-1] ? NUDGE_NEG : NUDGE_POS);
        // Divide by 2^(W-1) truncating toward zero, not flooring
        quot = (sum >>> (W-1)) +
               ((sum[2*W-1] && (sum[W-2:0] != '0)) ? ONE2 : '0);
        z_d  = ((y == WMIN) && (mult_q == WMIN)) ? WMAX : quot[W-1:0];
    end

    // S3: rounding divide by 2^right, ties away from zero
    logic [W-1:0] mask, rem, thr;
    always_comb begin
        mask = (W'(1) << rsh2_q) - W'(1);
        rem  = z_q & mask;
        thr  = (mask >> 1) + W'(z_q[W-1]);
        r_d  = (z_q >>> rsh2_q) + word_t'(rem > thr);
    end

    // S4: offset in W+1 bits, then act_min, act_max (last wins), int8 range
    wide_t s, lo, hi, c1, c2, c3;
    always_comb begin
        s    = $signed({r_q[W-1], r_q}) + $signed({offset_q[W-1], offset_q});
        lo   = $signed({amin_q[W-1], amin_q});
        hi   = $signed({amax_q[W-1], amax_q});
        c1   = (s < lo) ? lo : s;
        c2   = (c1 > hi) ? hi : c1;
        c3   = (c2 > QMAX) ? QMAX : ((c2 < QMIN) ? QMIN : c2);
        out_d = c3[B-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            left_q     <= '0;
            rsh1_q     <= '0;
            z_q        <= '0;
            rsh2_q     <= '0;
            r_q        <= '0;
            out_q      <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_fire};
            if (in_fire) acc_q <= $signed(bus.in_acc);
            if (vld_pipe_q[0]) begin
                x_q    <= x_d;
                left_q <= left_d;
                rsh1_q <= rsh1_d;
            end
            if (vld_pipe_q[1]) begin
                z_q    <= z_d;
                rsh2_q <= rsh1_q;
            end
            if (vld_pipe_q[2]) r_q   <= r_d;
            if (vld_pipe_q[3]) out_q <= out_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{quot[2*W-1:W], c3[W:B], neg_shift[SW-1]};
endmodule

// File: doc/conv1d_requant.md
# conv1d_requant

Streaming requantization stage directly downstream of the `conv1d` accumulator. It takes each signed 32-bit accumulator word and adds the per-layer bias. It then applies the fixed-point output multiplier and shift using TFLite `MultiplyByQuantizedMultiplier` semantics, adds the output offset and clamps to the activation range. The result is an int8 sample for write-back through the CFU response path.

## Interface
**Parameters**
- `INT32_SIZE`, default 32: accumulator and config word width.
- `BYTE_SIZE`, default 8: output sample width.

**Ports**
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_we`, in, 1: config write strobe.
- `cfg_sel`, in, 3: selects the config register. 0 = bias, 1 = output_multiplier, 2 = output_shift, 3 = output_offset, 4 = act_min, 5 = act_max; 6 and 7 are ignored.
- `cfg_data`, in, 32: config value, signed.
- `in_valid`, in, 1: accumulator word present.
- `in_ready`, out, 1: stage can accept.
- `in_acc`, in, 32: signed accumulator.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts.
- `out_data`, out, 8: signed int8 result.
- `busy`, out, 1: any pipeline stage holds valid data.
- `cfg_err`, out, 1: sticky flag; set when a config write arrives while busy.

## Operation
- **Pipeline:** 4 stages, S1..S4, each with a valid bit. The whole pipe advances when `adv = !out_valid || out_ready`. `in_ready = adv` (combinational). Input is accepted when `in_valid && in_ready`.
- **S1:** x = in_acc + bias, wrapping modulo 2^32. The shift is split as left = max(shift, 0) and right = max(-shift, 0).
  - `output_shift` is valid in [-31, 31].
  - Values outside that range are clamped to it when written.
- **S2:**
  - Compute y = x << left, keeping the low 32 bits (wraps).
  - Then apply SRDHM (saturating rounding doubling high multiply) with m = output_multiplier.
    - If y == m == INT32_MIN, the result is INT32_MAX.
    - Otherwise form p = y*m as a 64-bit signed product.
    - nudge = 2^30 if p ≥ 0, else 1 − 2^30.
    - z = (p + nudge) / 2^31, truncating toward zero (not an arithmetic shift).
- **S3:** Rounding divide by a power of two, with exponent e = right.
  - mask = 2^e − 1, rem = z & mask, thr = (mask >> 1) + (z < 0).
  - r = (z >>> e) + (rem > thr).
  - With e = 0 the value passes unchanged.
- **S4:** s = r + output_offset, computed in 33 bits with no wrap. Clamp s to [act_min, act_max], then to [-128, 127]. `out_data` is the low 8 bits.
- **Config:**
  - A write is applied only when `busy == 0` and no input handshake occurs in the same cycle.
  - Otherwise the write is dropped and `cfg_err` is set.
  - The same rule applies at `cfg_sel` 6 and 7, which are otherwise no-ops.
  - If act_min > act_max, the output is act_max (the max clamp is applied last).
- **Reset values:**
  - bias 0, multiplier 0x40000000, shift 0, offset 0, act_min −128, act_max 127.
  - All valid bits 0.
  - `out_valid` 0, `out_data` 0, `busy` 0, `cfg_err` 0, `in_ready` 1.

## Timing
- **Latency:** a word accepted at edge N appears with `out_valid` = 1 after edge N+4, provided there is no backpressure.
- **Throughput:** 1 word/cycle while `out_ready` = 1.
- **Stall:** while `out_valid && !out_ready`, every stage holds and `out_data` is stable.
  - No word is lost or duplicated.
  - `in_ready` is 0 for the whole stall.
- **Simultaneous events:** an output handshake and an input handshake in the same cycle are both honoured, because the pipe shifts.
- **Reset mid-stream:** asserting `rst_n` low clears all valid bits and config immediately (asynchronously). In-flight words are discarded.
- **`busy`:** the OR of the S1..S4 valid bits, registered.

## Test plan
- **Positive scaling:** defaults with offset −10, in_acc = 100 → out_data = 40 exactly 4 cycles after acceptance (SRDHM 100 → 50).
- **Rounding:**
  - Shift −1 with in_acc = 100 → 25.
  - Shift −2 with in_acc = 100 → 13 (50 >> 2 = 12, rem 2 > thr 1).
  - Negative case: in_acc = −100, shift 0 → −50.
- **Saturation and clamping:**
  - multiplier = INT32_MIN, bias 0, in_acc = INT32_MIN → 127.
  - Shift 2, in_acc = 100 → 127.
  - act_max = 20 with in_acc = 100 → 20.
- **Backpressure:** stream 16 words 0..15 with bias 0 and `out_ready` toggled pseudo-randomly. The outputs must match the reference model in order, with no drops or duplicates, and `out_data` must stay stable during stalls.
- **Config guard:** write bias while `busy` → value unchanged and `cfg_err` = 1. After a drain, a write takes effect for the next word. Reset clears `cfg_err`.
- **Async reset:** assert `rst_n` low with 3 words in flight → `out_valid` and `busy` drop immediately, and no stale output appears after release.
